// File: rtl/y86_pkg.sv
// ============================================================================
// Module   : y86_pkg
// Purpose  : Y86 shared encodings and the instruction-length helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [3:0] ALUADD  = 4'h0;
    localparam logic [3:0] ALUSUB  = 4'h1;
    localparam logic [3:0] ALUAND  = 4'h2;
    localparam logic [3:0] ALUXOR  = 4'h3;

    localparam logic [3:0] C_YES   = 4'h0;
    localparam logic [3:0] C_LE    = 4'h1;
    localparam logic [3:0] C_L     = 4'h2;
    localparam logic [3:0] C_E     = 4'h3;
    localparam logic [3:0] C_NE    = 4'h4;
    localparam logic [3:0] C_GE    = 4'h5;
    localparam logic [3:0] C_G     = 4'h6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Encoded length in bytes; 0 marks an invalid icode.
    function automatic logic [3:0] y86_instr_len(input logic [3:0] icode);
        case (icode)
            IHALT, INOP, IRET:              y86_instr_len = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:   y86_instr_len = 4'd2;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:      y86_instr_len = 4'd10;
            IJXX, ICALL:                    y86_instr_len = 4'd9;
            default:                        y86_instr_len = 4'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/y86_instr_check.sv
// ============================================================================
// Module   : y86_instr_check
// Purpose  : Combinational length / validity / field check of one Y86
//            instruction. Field checks exist only with Y86_FIELD_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module y86_instr_check
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic [3:0] i_ifun,
    input  logic [3:0] i_rA,
    input  logic [3:0] i_rB,
    output logic [3:0] o_len,
    output logic       o_valid,
    output logic       o_fields_ok
);

    always_comb begin
        o_len       = y86_instr_len(i_icode);
        o_valid     = (o_len != 4'd0);
        o_fields_ok = 1'b1;
`ifdef Y86_FIELD_CHECK_EN
        case (i_icode)
            IRRMOVQ, IJXX: if (i_ifun > 4'd6)  o_fields_ok = 1'b0;
            IOPQ:          if (i_ifun > 4'd3)  o_fields_ok = 1'b0;
            default:       if (i_ifun != 4'd0) o_fields_ok = 1'b0;
        endcase
        case (i_icode)
            IRRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ:
                if (i_rA == RNONE) o_fields_ok = 1'b0;
            default: ;
        endcase
        case (i_icode)
            IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ:
                if (i_rB == RNONE) o_fields_ok = 1'b0;
            default: ;
        endcase
`endif
    end

`ifndef Y86_FIELD_CHECK_EN
    logic w_unused;
    assign w_unused = ^{i_ifun, i_rA, i_rB};
`endif

endmodule

`default_nettype wire

// File: rtl/y86_imem_writer.sv
// ============================================================================
// Module   : y86_imem_writer
// Purpose  : Serialises one Y86 instruction per handshake into byte writes at
//            an auto-advancing pointer. Optional: Y86_FIELD_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module y86_imem_writer
    import y86_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_init,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W:0]   wr_ptr
);

    localparam logic [ADDR_W+1:0] c_MEM_END = (ADDR_W+2)'(MEM_DEPTH);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_idx, w_idx_nxt;
    logic [3:0]        r_len, w_len_nxt;
    logic [7:0]        r_b0, w_b0_nxt;
    logic [7:0]        r_b1, w_b1_nxt;
    logic [63:0]       r_valC, w_valC_nxt;
    logic [ADDR_W:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_ovf, w_ovf_nxt;

    logic [3:0]        w_len;
    logic              w_valid;
    logic              w_fields_ok;
    logic [3:0]        w_rA_eff;
    logic [3:0]        w_rB_eff;
    logic              w_accept;
    logic [ADDR_W+1:0] w_end;
    logic [3:0]        w_idx_inc;

    y86_instr_check u_check (
        .i_icode     (icode),
        .i_ifun      (ifun),
        .i_rA        (rA),
        .i_rB        (rB),
        .o_len       (w_len),
        .o_valid     (w_valid),
        .o_fields_ok (w_fields_ok)
    );

`ifdef Y86_FIELD_CHECK_EN
    assign w_rA_eff = (icode == IIRMOVQ) ? RNONE : rA;
    assign w_rB_eff = (icode == IPUSHQ || icode == IPOPQ) ? RNONE : rB;
`else
    assign w_rA_eff = rA;
    assign w_rB_eff = rB;
`endif

    // Byte k of the latched instruction; valC is little-endian after the header.
    function automatic logic [7:0] f_byte(
        input logic [3:0]  k,
        input logic [3:0]  len,
        input logic [7:0]  b0,
        input logic [7:0]  b1,
        input logic [63:0] c
    );
        logic [2:0] ci;
        ci = (len == 4'd10) ? 3'(k - 4'd2) : 3'(k - 4'd1);
        if (k == 4'd0)
            f_byte = b0;
        else if (k == 4'd1 && (len == 4'd2 || len == 4'd10))
            f_byte = b1;
        else
            f_byte = c[{ci, 3'b000} +: 8];
    endfunction

    assign in_ready  = (r_state == IDLE) && !addr_load && !r_ovf;
    assign w_accept  = in_valid && in_ready;
    assign w_end     = {1'b0, r_wr_ptr} + (ADDR_W+2)'(w_len);
    assign w_idx_inc = r_idx + 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_len_nxt       = r_len;
        w_b0_nxt        = r_b0;
        w_b1_nxt        = r_b1;
        w_valC_nxt      = r_valC;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_ovf_nxt       = r_ovf;
        case (r_state)
            IDLE: begin
                if (addr_load) begin
                    w_wr_ptr_nxt = {1'b0, addr_init};
                    w_ovf_nxt    = 1'b0;
                end else if (w_accept) begin
                    if (!w_valid || !w_fields_ok) begin
                        w_err_nxt = 1'b1;
                    end else if (w_end > c_MEM_END) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        // Byte 0 goes out on the acceptance edge itself.
                        w_state_nxt     = EMIT;
                        w_idx_nxt       = 4'd0;
                        w_len_nxt       = w_len;
                        w_b0_nxt        = {icode, ifun};
                        w_b1_nxt        = {w_rA_eff, w_rB_eff};
                        w_valC_nxt      = valC;
                        w_mem_we_nxt    = 1'b1;
                        w_mem_addr_nxt  = r_wr_ptr[ADDR_W-1:0];
                        w_mem_wdata_nxt = {icode, ifun};
                        w_done_nxt      = (w_len == 4'd1);
                    end
                end
            end
            EMIT: begin
                if (r_idx == r_len - 4'd1) begin
                    w_state_nxt  = IDLE;
                    w_wr_ptr_nxt = r_wr_ptr + (ADDR_W+1)'(r_len);
                end else begin
                    w_idx_nxt       = w_idx_inc;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = r_wr_ptr[ADDR_W-1:0] + ADDR_W'(w_idx_inc);
                    w_mem_wdata_nxt = f_byte(w_idx_inc, r_len, r_b0, r_b1, r_valC);
                    w_done_nxt      = (w_idx_inc == r_len - 4'd1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 4'd0;
            r_len       <= 4'd0;
            r_b0        <= 8'd0;
            r_b1        <= 8'd0;
            r_valC      <= 64'd0;
            r_wr_ptr    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_len       <= w_len_nxt;
            r_b0        <= w_b0_nxt;
            r_b1        <= w_b1_nxt;
            r_valC      <= w_valC_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = r_done;
    assign err       = r_err;
    assign ovf       = r_ovf;
    assign wr_ptr    = r_wr_ptr;

endmodule

`default_nettype wire

// File: tb/tb_y86_imem_writer.sv
// ============================================================================
// Module   : tb_y86_imem_writer
// Purpose  : Self-checking bench for y86_imem_writer (default build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_y86_imem_writer;

    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_W    = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        icode = '0, ifun = '0, rA = '0, rB = '0;
    logic [63:0]       valC = '0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_init = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              done, err, ovf;
    logic [ADDR_W:0]   wr_ptr;

    always #5 clk = ~clk;

    y86_imem_writer #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
        .addr_load(addr_load), .addr_init(addr_init),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err(err), .ovf(ovf), .wr_ptr(wr_ptr)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              last;
    } wr_t;

    typedef struct {
        logic [3:0]  ic, f, a, b;
        logic [63:0] v;
    } vec_t;

    wr_t  sb[$];
    vec_t tbl[16];
    int   n_vec = 0;
    int   n_err = 0;
    int   model_ptr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            4'h7, 4'h8:             return 9;
            default:                return 0;
        endcase
    endfunction

    // Scoreboard consumer: every write must match the next expected byte.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rst_n) begin
            if (mem_we) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0d data %02h, none expected", mem_addr, mem_wdata);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                    check("wr_done", done, e.last);
                end
            end else begin
                check("done_without_we", done, 0);
            end
        end
    end

    task automatic send(input logic [3:0] ic, f, a, b, input logic [63:0] v,
                        input bit use_lit, input logic [79:0] lit, input bit poke);
        int L, t, off;
        bit bad, over;
        logic [7:0] bt;
        L    = exp_len(ic);
        bad  = (L == 0);
        over = !bad && (model_ptr + L > MEM_DEPTH);
        t    = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", in_ready, 1);
        icode = ic; ifun = f; rA = a; rB = b; valC = v; in_valid = 1'b1;
        if (!bad && !over) begin
            for (int k = 0; k < L; k++) begin
                if (use_lit) bt = lit[79-8*k -: 8];
                else if (k == 0) bt = {ic, f};
                else if (k == 1 && (L == 2 || L == 10)) bt = {a, b};
                else begin
                    off = (L == 10) ? 2 : 1;
                    bt  = v[8*(k-off) +: 8];
                end
                sb.push_back('{addr: ADDR_W'(model_ptr + k), data: bt, last: (k == L-1)});
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (bad) begin
            @(negedge clk);
            check("err_pulse", err, 1);
            check("err_no_we", mem_we, 0);
            @(negedge clk);
            check("err_clear", err, 0);
            check("err_ptr", wr_ptr, model_ptr);
        end else if (over) begin
            @(negedge clk);
            check("ovf_set", ovf, 1);
            check("ovf_ready", in_ready, 0);
            check("ovf_ptr", wr_ptr, model_ptr);
        end else begin
            for (int k = 0; k < L; k++) begin
                @(negedge clk);
                check("we_burst", mem_we, 1);
                check("burst_not_ready", in_ready, 0);
                addr_load = poke && (k == 1);
                addr_init = ADDR_W'(500);
            end
            addr_load = 1'b0;
            @(negedge clk);
            model_ptr += L;
            check("idle_ready", in_ready, 1);
            check("idle_we", mem_we, 0);
            check("wr_ptr", wr_ptr, model_ptr);
        end
    endtask

    task automatic load(input int a, input bit with_valid);
        @(negedge clk);
        addr_load = 1'b1;
        addr_init = ADDR_W'(a);
        if (with_valid) begin
            icode = 4'h1; ifun = 4'h0; in_valid = 1'b1;
        end
        #1 check("load_ready_low", in_ready, 0);
        @(posedge clk);
        #1 addr_load = 1'b0;
        in_valid = 1'b0;
        model_ptr = a;
        @(negedge clk);
        check("load_ptr", wr_ptr, a);
        check("load_ovf", ovf, 0);
        check("load_ready", in_ready, 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 64'h0};
        tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 64'h0};
        tbl[2]  = '{4'h2, 4'h0, 4'h3, 4'h4, 64'h0};
        tbl[3]  = '{4'h3, 4'h0, 4'hF, 4'h7, 64'h0123456789ABCDEF};
        tbl[4]  = '{4'h4, 4'h0, 4'h1, 4'h2, 64'hFFFFFFFFFFFFFFF8};
        tbl[5]  = '{4'h5, 4'h0, 4'h6, 4'h5, 64'h80};
        tbl[6]  = '{4'h6, 4'h1, 4'h2, 4'h3, 64'h0};
        tbl[7]  = '{4'h7, 4'h6, 4'hF, 4'hF, 64'h1234};
        tbl[8]  = '{4'h8, 4'h0, 4'hF, 4'hF, 64'hDEADBEEF00000100};
        tbl[9]  = '{4'h9, 4'h0, 4'h0, 4'h0, 64'h0};
        tbl[10] = '{4'hA, 4'h0, 4'h3, 4'hF, 64'h0};
        tbl[11] = '{4'hB, 4'h0, 4'h8, 4'hF, 64'h0};
        tbl[12] = '{4'hC, 4'h0, 4'h1, 4'h2, 64'h55};
        tbl[13] = '{4'hD, 4'h0, 4'h1, 4'h2, 64'h55};
        tbl[14] = '{4'hE, 4'h0, 4'h1, 4'h2, 64'h55};
        tbl[15] = '{4'hF, 4'h0, 4'h1, 4'h2, 64'h55};

        #12;
        check("rst_we", mem_we, 0);
        check("rst_ptr", wr_ptr, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b1, 80'h00_000000000000000000, 1'b0);

        load(6, 1'b0);
        send(4'h3, 4'h0, 4'hF, 4'h2, 64'hABCD, 1'b1, 80'h30F2CDAB000000000000, 1'b0);

        load(0, 1'b0);
        send(4'h7, 4'h2, 4'hF, 4'hF, 64'h400, 1'b1, 80'h72000400000000000000, 1'b0);

        send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 80'h0, 1'b0);

        load(1020, 1'b0);
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'h10, 1'b0, 80'h0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; icode = 4'h1;
        repeat (3) begin
            @(negedge clk);
            check("ovf_hold_ready", in_ready, 0);
            check("ovf_hold", ovf, 1);
        end
        in_valid = 1'b0;
        load(0, 1'b0);

        for (int i = 0; i < 16; i++)
            send(tbl[i].ic, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].v, 1'b0, 80'h0, 1'b0);

        // addr_load pulsed mid-burst must be ignored.
        send(4'h5, 4'h0, 4'h1, 4'h4, 64'h77, 1'b0, 80'h0, 1'b1);

        // addr_load wins over a simultaneous in_valid.
        load(200, 1'b1);

        load(1014, 1'b0);
        send(4'h3, 4'h0, 4'hF, 4'h1, 64'h1122334455667788, 1'b0, 80'h0, 1'b0);
        check("full_ptr", wr_ptr, MEM_DEPTH);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 80'h0, 1'b0);
        load(40, 1'b0);

        // Reset in the middle of an irmovq after three bytes.
        @(negedge clk);
        icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h3; valC = 64'h99; in_valid = 1'b1;
        sb.push_back('{addr: ADDR_W'(40), data: 8'h30, last: 1'b0});
        sb.push_back('{addr: ADDR_W'(41), data: 8'hF3, last: 1'b0});
        sb.push_back('{addr: ADDR_W'(42), data: 8'h99, last: 1'b0});
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_ptr", wr_ptr, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        check("postrst_ready", in_ready, 1);
        check("postrst_we", mem_we, 0);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 80'h0, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
